// File: rtl/cla_sched_pkg.sv
// rtl/cla_sched_pkg.sv - KPG carry characters and scheduler state encoding
package cla_sched_pkg;

  localparam logic [7:0] KPG_K = 8'h6B;
  localparam logic [7:0] KPG_G = 8'h67;
  localparam logic [7:0] KPG_P = 8'h70;

  typedef enum logic [1:0] {
    IDLE,
    LO,
    HI,
    RESP
  } state_t;

endpackage

// File: rtl/cla_add_scheduler_rr_arbiter.sv
// rtl/cla_add_scheduler_rr_arbiter.sv - one-hot requester arbiter, rotating or fixed priority
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int RR = 1,
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] i_req,
  input  logic            i_advance,
  output logic [NREQ-1:0] o_grant,
  output logic [IDW-1:0]  o_grant_idx
);

  logic [IDW-1:0] r_last;
  int             w_start;
  int             w_j;

  // Scan from the highest offset down so the first requester after the start point wins.
  always_comb begin
    o_grant     = '0;
    o_grant_idx = '0;
    w_j         = 0;
    w_start     = (RR != 0) ? int'(r_last) + 1 : 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_j = w_start + k;
      if (w_j >= NREQ) w_j = w_j - NREQ;
      if (i_req[w_j]) begin
        o_grant      = '0;
        o_grant[w_j] = 1'b1;
        o_grant_idx  = IDW'(w_j);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last <= IDW'(NREQ - 1);
    end else if (i_advance) begin
      r_last <= o_grant_idx;
    end
  end

endmodule

// File: rtl/cla_add_scheduler.sv
// rtl/cla_add_scheduler.sv - shares one 64-bit KPG adder for narrow and two-pass wide add/sub
module cla_add_scheduler
  import cla_sched_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int RR = 1,
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [NREQ*128-1:0] req_a,
  input  logic [NREQ*128-1:0] req_b,
  input  logic [NREQ-1:0]     req_wide,
  input  logic [NREQ-1:0]     req_sub,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [IDW-1:0]      rsp_id,
  output logic [127:0]        rsp_sum,
  output logic                rsp_cout,
  output logic [63:0]         add_a,
  output logic [63:0]         add_b,
  output logic [7:0]          add_xin,
  input  logic [63:0]         add_sum,
  input  logic [7:0]          add_xout
);

  state_t         r_state;
  logic [127:0]   r_a;
  logic [127:0]   r_b;
  logic [127:0]   r_sum;
  logic           r_wide;
  logic           r_sub;
  logic           r_carry;
  logic [IDW-1:0] r_id;

  logic [NREQ-1:0] w_grant;
  logic [IDW-1:0]  w_grant_idx;
  logic            w_accept;
  logic            w_xcarry;
  logic [127:0]    w_sel_a;
  logic [127:0]    w_sel_b;
  logic            w_sel_wide;
  logic            w_sel_sub;

  rr_arbiter #(
    .NREQ(NREQ),
    .RR  (RR)
  ) u_arb (
    .clk        (clk),
    .rst        (rst),
    .i_req      (req_valid),
    .i_advance  (w_accept),
    .o_grant    (w_grant),
    .o_grant_idx(w_grant_idx)
  );

  assign req_ready = (r_state == IDLE) ? w_grant : '0;
  assign w_accept  = |(req_valid & req_ready);
  // Only a resolved generate counts as carry; propagate or kill both mean 0.
  assign w_xcarry  = (add_xout == KPG_G);

  assign rsp_valid = (r_state == RESP);
  assign rsp_sum   = r_sum;
  assign rsp_id    = r_id;
  assign rsp_cout  = r_carry;

  always_comb begin
    w_sel_a    = '0;
    w_sel_b    = '0;
    w_sel_wide = 1'b0;
    w_sel_sub  = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_grant[i]) begin
        w_sel_a    = req_a[128*i +: 128];
        w_sel_b    = req_b[128*i +: 128];
        w_sel_wide = req_wide[i];
        w_sel_sub  = req_sub[i];
      end
    end
  end

  // Subtraction is A + ~B + 1, the +1 entering as a generate on the low pass.
  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_xin = KPG_K;
    case (r_state)
      LO: begin
        add_a   = r_a[63:0];
        add_b   = r_sub ? ~r_b[63:0] : r_b[63:0];
        add_xin = r_sub ? KPG_G : KPG_K;
      end
      HI: begin
        add_a   = r_a[127:64];
        add_b   = r_sub ? ~r_b[127:64] : r_b[127:64];
        add_xin = r_carry ? KPG_G : KPG_K;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_wide  <= 1'b0;
      r_sub   <= 1'b0;
      r_id    <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_a     <= w_sel_a;
            r_b     <= w_sel_b;
            r_wide  <= w_sel_wide;
            r_sub   <= w_sel_sub;
            r_id    <= w_grant_idx;
            r_state <= LO;
          end
        end
        LO: begin
          r_sum   <= {64'h0, add_sum};
          r_carry <= w_xcarry;
          r_state <= r_wide ? HI : RESP;
        end
        HI: begin
          r_sum[127:64] <= add_sum;
          r_carry       <= w_xcarry;
          r_state       <= RESP;
        end
        RESP: begin
          if (rsp_ready) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cla_add_scheduler.sv
// tb/tb_cla_add_scheduler.sv - directed and randomized checks of the shared-adder scheduler
module tb_cla_add_scheduler;

  localparam int N0 = 3;
  localparam logic [7:0] K = 8'h6B;
  localparam logic [7:0] G = 8'h67;
  localparam logic [7:0] P = 8'h70;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst;
  logic [N0-1:0]       req_valid, req_ready, req_wide, req_sub;
  logic [N0*128-1:0]   req_a, req_b;
  logic                rsp_valid, rsp_ready, rsp_cout;
  logic [1:0]          rsp_id;
  logic [127:0]        rsp_sum;
  logic [63:0]         add_a, add_b, add_sum;
  logic [7:0]          add_xin, add_xout;
  logic [64:0]         add_full;
  logic                p_sel = 1'b0;

  logic [1:0]   f_valid, f_ready, f_wide, f_sub;
  logic [255:0] f_a, f_b;
  logic         f_rsp_valid, f_rsp_ready, f_rsp_cout;
  logic [0:0]   f_rsp_id;
  logic [127:0] f_rsp_sum;
  logic [63:0]  f_add_a, f_add_b, f_add_sum;
  logic [7:0]   f_add_xin, f_add_xout;

  // Behavioural shared adder; an unresolved carry-out is sometimes reported as "p".
  always @(posedge clk) p_sel <= ~p_sel;
  assign add_full   = {1'b0, add_a} + {1'b0, add_b} + {64'h0, add_xin == G};
  assign add_sum    = add_full[63:0];
  assign add_xout   = add_full[64] ? G : (p_sel ? P : K);
  assign f_add_sum  = f_add_a + f_add_b + {63'h0, f_add_xin == G};
  assign f_add_xout = K;

  cla_add_scheduler #(.NREQ(N0), .RR(1)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_wide(req_wide), .req_sub(req_sub),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_sum(rsp_sum), .rsp_cout(rsp_cout), .add_a(add_a), .add_b(add_b),
    .add_xin(add_xin), .add_sum(add_sum), .add_xout(add_xout)
  );

  cla_add_scheduler #(.NREQ(2), .RR(0)) dut_fp (
    .clk(clk), .rst(rst), .req_valid(f_valid), .req_ready(f_ready),
    .req_a(f_a), .req_b(f_b), .req_wide(f_wide), .req_sub(f_sub),
    .rsp_valid(f_rsp_valid), .rsp_ready(f_rsp_ready), .rsp_id(f_rsp_id),
    .rsp_sum(f_rsp_sum), .rsp_cout(f_rsp_cout), .add_a(f_add_a), .add_b(f_add_b),
    .add_xin(f_add_xin), .add_sum(f_add_sum), .add_xout(f_add_xout)
  );

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic int arb(input logic [N0-1:0] v, input int last);
    for (int k = 1; k <= N0; k++) begin
      if (v[(last + k) % N0]) return (last + k) % N0;
    end
    return -1;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Reference model: timeline of one op at a time, results from plain arithmetic.
  bit            m_armed = 0, m_idle = 1, m_wide, m_sub, e_cout, e_loc, in_resp;
  int            m_age, m_last = N0 - 1, m_id, g;
  logic [127:0]  m_a, m_b, e_sum;
  logic [N0-1:0] e_ready;
  logic [63:0]   e_aa, e_ab;
  logic [7:0]    e_x;
  logic [128:0]  t129;
  logic [64:0]   t65;

  always @(negedge clk) begin
    if (rst) begin
      m_idle  = 1;
      m_last  = N0 - 1;
      m_armed = 1;
    end else if (m_armed) begin
      e_ready = '0;
      g = -1;
      if (m_idle) begin
        g = arb(req_valid, m_last);
        if (g >= 0) e_ready[g] = 1'b1;
      end
      check("m_req_ready", req_ready, e_ready);
      in_resp = !m_idle && (m_age >= (m_wide ? 3 : 2));
      check("m_rsp_valid", rsp_valid, in_resp);
      if (in_resp) begin
        check("m_rsp_sum", rsp_sum, e_sum);
        check("m_rsp_cout", rsp_cout, e_cout);
        check("m_rsp_id", rsp_id, m_id);
      end
      e_aa = '0;
      e_ab = '0;
      e_x  = K;
      if (!m_idle && m_age == 1) begin
        e_aa = m_a[63:0];
        e_ab = m_sub ? ~m_b[63:0] : m_b[63:0];
        e_x  = m_sub ? G : K;
      end else if (!m_idle && m_wide && m_age == 2) begin
        e_aa = m_a[127:64];
        e_ab = m_sub ? ~m_b[127:64] : m_b[127:64];
        e_x  = e_loc ? G : K;
      end
      check("m_add_a", add_a, e_aa);
      check("m_add_b", add_b, e_ab);
      check("m_add_xin", add_xin, e_x);
      if (m_idle) begin
        if (g >= 0) begin
          m_a    = req_a[g*128 +: 128];
          m_b    = req_b[g*128 +: 128];
          m_wide = req_wide[g];
          m_sub  = req_sub[g];
          m_id   = g;
          m_last = g;
          m_idle = 0;
          m_age  = 1;
          t65  = {1'b0, m_a[63:0]} + {1'b0, m_b[63:0]};
          t129 = {1'b0, m_a} + {1'b0, m_b};
          e_loc = m_sub ? (m_a[63:0] >= m_b[63:0]) : t65[64];
          if (m_wide) begin
            e_sum  = m_sub ? m_a - m_b : t129[127:0];
            e_cout = m_sub ? (m_a >= m_b) : t129[128];
          end else begin
            e_sum  = m_sub ? {64'h0, m_a[63:0] - m_b[63:0]} : {64'h0, t65[63:0]};
            e_cout = e_loc;
          end
        end
      end else if (in_resp && rsp_ready) begin
        m_idle = 1;
      end else begin
        m_age++;
      end
    end
  end

  task automatic do_op(input int idx, input logic [127:0] a, input logic [127:0] b,
                       input bit wide, input bit sub, input logic [127:0] es, input bit ec,
                       input int elat, input logic [7:0] exlo, input logic [7:0] exhi,
                       input string nm);
    int lat;
    bit got;
    logic [7:0] xlo, xhi;
    @(posedge clk); #1;
    req_a[idx*128 +: 128] = a;
    req_b[idx*128 +: 128] = b;
    req_wide[idx] = wide;
    req_sub[idx]  = sub;
    req_valid     = N0'(1 << idx);
    rsp_ready     = 1'b1;
    got = 0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      got = req_ready[idx];
    end
    check({nm, "_accept"}, got, 1);
    @(posedge clk); #1;
    req_valid = '0;
    lat = 0; got = 0; xlo = 0; xhi = 0;
    for (int k = 1; k <= 10 && !got; k++) begin
      @(negedge clk);
      if (k == 1) xlo = add_xin;
      if (k == 2) xhi = add_xin;
      if (rsp_valid) begin
        got = 1;
        lat = k;
      end
    end
    check({nm, "_latency"}, lat, elat);
    check({nm, "_sum"}, rsp_sum, es);
    check({nm, "_cout"}, rsp_cout, ec);
    check({nm, "_id"}, rsp_id, idx);
    check({nm, "_xin_lo"}, xlo, exlo);
    if (wide) check({nm, "_xin_hi"}, xhi, exhi);
    @(posedge clk); #1;
  endtask

  int n0, n1;
  int ids0[4], ids1[4];
  bit got;
  int mode;

  initial begin
    rst = 1; req_valid = '0; req_wide = '0; req_sub = '0; req_a = '0; req_b = '0; rsp_ready = 0;
    f_valid = '0; f_rsp_ready = 0; f_wide = '0; f_sub = '0; f_a = '0; f_b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_sum", rsp_sum, 0);
    check("rst_rsp_id", rsp_id, 0);
    check("rst_rsp_cout", rsp_cout, 0);
    check("rst_add_a", add_a, 0);
    check("rst_add_b", add_b, 0);
    check("rst_add_xin", add_xin, K);

    // Arbitration: two requesters always valid, consumer always ready.
    @(posedge clk); #1;
    rst = 0; req_valid = 3'b011; rsp_ready = 1; f_valid = 2'b11; f_rsp_ready = 1;
    n0 = 0; n1 = 0;
    for (int i = 0; i < 4; i++) begin ids0[i] = 9; ids1[i] = 9; end
    for (int c = 0; c < 40 && (n0 < 4 || n1 < 4); c++) begin
      @(negedge clk);
      if (f_ready !== 2'b00) check("fp_ready_onehot", f_ready, 2'b01);
      if (rsp_valid && n0 < 4) begin ids0[n0] = rsp_id; n0++; end
      if (f_rsp_valid && n1 < 4) begin
        ids1[n1] = f_rsp_id; n1++;
        check("fp_sum", f_rsp_sum, 0);
        check("fp_cout", f_rsp_cout, 0);
      end
    end
    check("rr_resp_count", n0, 4);
    check("fp_resp_count", n1, 4);
    for (int i = 0; i < 4; i++) begin
      check("rr_id_seq", ids0[i], i % 2);
      check("fp_id_seq", ids1[i], 0);
    end
    @(posedge clk); #1;
    req_valid = '0; f_valid = '0;
    repeat (6) @(posedge clk);
    #1;

    do_op(0, {64'hDEAD_BEEF_0123_4567, 64'hFFFF_FFFF_FFFF_FFFF}, {64'h5555_5555_5555_5555, 64'h1},
          0, 0, 128'h0, 1, 2, K, K, "narrow_add");
    do_op(0, 128'h0000_0000_0000_0001_FFFF_FFFF_FFFF_FFFF, 128'h1,
          1, 0, 128'h2_0000_0000_0000_0000, 0, 3, K, G, "wide_chain");
    do_op(0, 128'h5, 128'h7, 0, 1, 128'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFE, 0, 2, G, K, "sub_borrow");
    do_op(2, 128'h7, 128'h5, 0, 1, 128'h2, 1, 2, G, K, "sub_noborrow");

    // Backpressure: response held while consumer stalls.
    @(posedge clk); #1;
    req_a[127:0] = 128'h3; req_b[127:0] = 128'h4; req_wide[0] = 0; req_sub[0] = 0;
    req_valid = 3'b001; rsp_ready = 0;
    @(negedge clk);
    check("bp_grant", req_ready, 3'b001);
    @(posedge clk); #1;
    req_valid = 3'b010;
    got = 0;
    for (int c = 0; c < 10 && !got; c++) begin
      @(negedge clk);
      got = rsp_valid;
    end
    check("bp_valid_seen", got, 1);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      check("bp_hold_valid", rsp_valid, 1);
      check("bp_hold_sum", rsp_sum, 128'h7);
      check("bp_hold_id", rsp_id, 0);
      check("bp_hold_cout", rsp_cout, 0);
      check("bp_hold_ready", req_ready, 0);
    end
    @(posedge clk); #1;
    rsp_ready = 1;
    @(negedge clk);
    check("bp_release_valid", rsp_valid, 1);
    @(negedge clk);
    check("bp_idle_valid", rsp_valid, 0);
    check("bp_idle_ready", req_ready, 3'b010);
    @(posedge clk); #1;
    req_valid = '0;
    repeat (6) @(posedge clk);
    #1;

    // Reset during the high pass of a wide op from requester 0.
    req_a[127:0] = rnd128(); req_b[127:0] = rnd128(); req_wide[0] = 1; req_sub[0] = 0;
    req_valid = 3'b001;
    @(negedge clk);
    check("rst_mid_grant", req_ready, 3'b001);
    @(posedge clk); #1;
    req_valid = 3'b011;
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    check("rst_mid_no_rsp", rsp_valid, 0);
    check("rst_mid_next_grant", req_ready, 3'b001);
    @(posedge clk); #1;
    req_valid = '0;
    repeat (6) @(posedge clk);

    // Randomized traffic, operand churn every cycle, occasional reset.
    for (int c = 0; c < 600; c++) begin
      @(posedge clk); #1;
      rst = ($urandom_range(0, 149) == 0);
      req_valid = N0'($urandom);
      req_wide  = N0'($urandom);
      req_sub   = N0'($urandom);
      rsp_ready = ($urandom_range(0, 9) < 7);
      for (int i = 0; i < N0; i++) begin
        mode = $urandom_range(0, 3);
        req_b[i*128 +: 128] = rnd128();
        case (mode)
          0: req_a[i*128 +: 128] = rnd128();
          1: req_a[i*128 +: 128] = '1;
          2: req_a[i*128 +: 128] = req_b[i*128 +: 128];
          default: req_a[i*128 +: 128] = {96'h0, $urandom};
        endcase
      end
    end
    @(posedge clk); #1;
    rst = 0; req_valid = '0; rsp_ready = 1;
    repeat (8) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
